// File: rtl/aes_mode_ctrl_if.sv
// Host and core-side signal bundle for aes_mode_ctrl. The host drives through "master";
// the controller sits on "slave".
interface aes_mode_ctrl_if #(
    parameter int unsigned BLK_S  = 128,
    parameter int unsigned KEY_S  = 128,
    parameter int unsigned WORD_S = 32
);
    logic                en;
    logic [0:WORD_S-1]   aes_cmd;
    logic [KEY_S-1:0]    aes_key;
    logic [BLK_S-1:0]    aes_iv;
    logic [BLK_S-1:0]    aes_plaintext;
    logic [BLK_S-1:0]    aes_ciphertext;
    logic                en_o;
    logic                err_o;
    logic                busy;
    logic [BLK_S-1:0]    iv_o;
    logic                core_en;
    logic [0:WORD_S-1]   core_cmd;
    logic [KEY_S-1:0]    core_key;
    logic [BLK_S-1:0]    core_blk;
    logic [BLK_S-1:0]    core_out;
    logic                core_en_o;

    modport master (
        output en, aes_cmd, aes_key, aes_iv, aes_plaintext, core_out, core_en_o,
        input  aes_ciphertext, en_o, err_o, busy, iv_o, core_en, core_cmd, core_key, core_blk
    );

    modport slave (
        input  en, aes_cmd, aes_key, aes_iv, aes_plaintext, core_out, core_en_o,
        output aes_ciphertext, en_o, err_o, busy, iv_o, core_en, core_cmd, core_key, core_blk
    );
endinterface

// File: rtl/aes_mode_ctrl.sv
// ECB/CBC/CTR chaining controller in front of the aes_top core (pulse handshake).
// Define AES_CTR_EN to build CTR mode and its counter incrementer; otherwise 0x40 is unknown.
module aes_mode_ctrl #(
    parameter int unsigned BLK_S  = 128,
    parameter int unsigned KEY_S  = 128,
    parameter int unsigned WORD_S = 32,
    parameter int unsigned CTR_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    aes_mode_ctrl_if.slave     bus
);
    localparam logic [7:0] OpSetKey = 8'h01;
    localparam logic [7:0] OpSetIv  = 8'h02;
    localparam logic [7:0] OpEcb    = 8'h10;
    localparam logic [7:0] OpCbc    = 8'h20;
`ifdef AES_CTR_EN
    localparam logic [7:0] OpCtr    = 8'h40;
`endif

    if (CTR_W < 1 || CTR_W > BLK_S) begin : g_ctr_w_check
        $error("CTR_W must be within 1..BLK_S");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e             state_q, state_d;
    logic [7:0]         op_q, op_d;
    logic [KEY_S-1:0]   key_q, key_d;
    logic [BLK_S-1:0]   pt_q, pt_d;
    logic [BLK_S-1:0]   iv_q, iv_d;
    logic [BLK_S-1:0]   res_q, res_d;
    logic               err_q, err_d;

    logic [7:0]         op_in;
    logic               op_uses_core;
    logic               unused_cmd;

    assign op_in      = bus.aes_cmd[0:7];
    assign unused_cmd = ^bus.aes_cmd[8:WORD_S-1];

`ifdef AES_CTR_EN
    // Only the low CTR_W bits count; the carry out of them is discarded.
    localparam logic [BLK_S-1:0] CtrMask = {BLK_S{1'b1}} >> (BLK_S - CTR_W);
    logic [BLK_S-1:0] iv_inc;
    assign iv_inc       = (iv_q & ~CtrMask) | ((iv_q + BLK_S'(1)) & CtrMask);
    assign op_uses_core = (op_in == OpSetKey) || (op_in == OpEcb) || (op_in == OpCbc) ||
                          (op_in == OpCtr);
`else
    assign op_uses_core = (op_in == OpSetKey) || (op_in == OpEcb) || (op_in == OpCbc);
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        key_d   = key_q;
        pt_d    = pt_q;
        iv_d    = iv_q;
        res_d   = res_q;
        err_d   = err_q;
        unique case (state_q)
            // DONE accepts a new command exactly like IDLE for back-to-back streaming.
            StIdle, StDone: begin
                state_d = StIdle;
                err_d   = 1'b0;
                if (bus.en) begin
                    if (op_in == OpSetIv) begin
                        iv_d    = bus.aes_iv;
                        state_d = StDone;
                    end else if (op_uses_core) begin
                        op_d    = op_in;
                        key_d   = bus.aes_key;
                        pt_d    = bus.aes_plaintext;
                        state_d = StIssue;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (bus.core_en_o) begin
                    state_d = StDone;
                    case (op_q)
                        OpEcb: res_d = bus.core_out;
                        OpCbc: begin
                            res_d = bus.core_out;
                            iv_d  = bus.core_out;
                        end
`ifdef AES_CTR_EN
                        OpCtr: begin
                            res_d = pt_q ^ bus.core_out;
                            iv_d  = iv_inc;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            op_q    <= '0;
            key_q   <= '0;
            pt_q    <= '0;
            iv_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            key_q   <= key_d;
            pt_q    <= pt_d;
            iv_q    <= iv_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    logic               issue;
    logic [0:WORD_S-1]  core_cmd;
    logic [BLK_S-1:0]   core_blk;

    assign issue = (state_q == StIssue);

    // The core sees SET_KEY or a plain single-block encrypt; chaining stays here.
    always_comb begin
        core_cmd = '0;
        core_blk = '0;
        if (issue) begin
            core_cmd[0:7] = (op_q == OpSetKey) ? OpSetKey : OpEcb;
            case (op_q)
                OpCbc:   core_blk = pt_q ^ iv_q;
`ifdef AES_CTR_EN
                OpCtr:   core_blk = iv_q;
`endif
                default: core_blk = pt_q;
            endcase
        end
    end

    assign bus.core_en        = issue;
    assign bus.core_cmd       = core_cmd;
    assign bus.core_key       = issue ? key_q : '0;
    assign bus.core_blk       = core_blk;
    assign bus.aes_ciphertext = res_q;
    assign bus.iv_o           = iv_q;
    assign bus.en_o           = (state_q == StDone);
    assign bus.err_o          = (state_q == StDone) && err_q;
    assign bus.busy           = issue || (state_q == StWait);
endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Directed bench for aes_mode_ctrl with a table-driven stand-in for the aes_top core.
// Covers the CTR cases when AES_CTR_EN is defined, otherwise checks that 0x40 is rejected.
module tb_aes_mode_ctrl;
    localparam int CoreLat = 4;
    localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1   = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C1   = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] C2   = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] Spur = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_mode_ctrl_if bus_if ();

    aes_mode_ctrl dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Known AES-128 vectors; other blocks get key^block so mis-built inputs still show up.
    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] b);
        if (k == K1 && b == 128'h00112233445566778899aabbccddeeff)
            return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        if (k == K2 && b == 128'h6bc0bce12a459991e134741a7f9e1925) return C1;
        if (k == K2 && b == 128'hd86421fb9f1a1eda505ee1375746972c) return C2;
        if (k == K2 && b == 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff)
            return 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
        return k ^ b;
    endfunction

    logic [127:0] mdl_key;
    logic [127:0] mdl_out;
    int           mdl_cnt;
    logic         spur_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_cnt <= 0;
            mdl_key <= '0;
            mdl_out <= '0;
        end else if (bus_if.core_en) begin
            mdl_cnt <= CoreLat;
            if (bus_if.core_cmd[0:7] == 8'h01) mdl_key <= bus_if.core_key;
            else mdl_out <= aes_ref(mdl_key, bus_if.core_blk);
        end else if (mdl_cnt != 0) begin
            mdl_cnt <= mdl_cnt - 1;
        end
    end

    assign bus_if.core_en_o = (mdl_cnt == 1) || spur_done;
    assign bus_if.core_out  = spur_done ? Spur : mdl_out;

    task automatic drive(input logic [7:0] op, input logic [127:0] key,
                         input logic [127:0] iv, input logic [127:0] pt);
        bus_if.en            = 1'b1;
        bus_if.aes_cmd       = {op, 24'h0};
        bus_if.aes_key       = key;
        bus_if.aes_iv        = iv;
        bus_if.aes_plaintext = pt;
    endtask

    // Starts just after a negedge; returns just after the negedge following en_o.
    task automatic run_op(input string tag, input logic [7:0] op, input logic [127:0] key,
                          input logic [127:0] iv, input logic [127:0] pt,
                          input int exp_lat, input logic exp_err);
        int lat;
        drive(op, key, iv, pt);
        @(negedge clk);
        bus_if.en = 1'b0;
        if (exp_lat > 1) begin
            check_eq({tag, " busy"}, 128'(bus_if.busy), 128'd1);
            check_eq({tag, " core_en"}, 128'(bus_if.core_en), 128'd1);
            check_eq({tag, " core_key"}, bus_if.core_key, key);
        end
        lat = 1;
        while (!bus_if.en_o && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, " latency"}, 128'(lat), 128'(exp_lat));
        check_eq({tag, " err_o"}, 128'(bus_if.err_o), 128'(exp_err));
        check_eq({tag, " busy at done"}, 128'(bus_if.busy), 128'd0);
        @(negedge clk);
        check_eq({tag, " en_o one cycle"}, 128'(bus_if.en_o), 128'd0);
    endtask

    logic [127:0] exp_iv;
    logic [127:0] exp_ct;

    initial begin
        int lat;
        int pulses;
        spur_done            = 1'b0;
        bus_if.en            = 1'b0;
        bus_if.aes_cmd       = '0;
        bus_if.aes_key       = '0;
        bus_if.aes_iv        = '0;
        bus_if.aes_plaintext = '0;
        repeat (2) @(negedge clk);
        check_eq("reset ciphertext", bus_if.aes_ciphertext, 128'd0);
        check_eq("reset iv_o", bus_if.iv_o, 128'd0);
        check_eq("reset en_o", 128'(bus_if.en_o), 128'd0);
        check_eq("reset err_o", 128'(bus_if.err_o), 128'd0);
        check_eq("reset busy", 128'(bus_if.busy), 128'd0);
        check_eq("reset core_en", 128'(bus_if.core_en), 128'd0);
        check_eq("reset core_cmd", 128'(bus_if.core_cmd), 128'd0);
        check_eq("reset core_blk", bus_if.core_blk, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("set_key1", 8'h01, K1, '0, '0, CoreLat + 2, 1'b0);
        run_op("ecb", 8'h10, K1, '0, 128'h00112233445566778899aabbccddeeff, CoreLat + 2, 1'b0);
        check_eq("ecb ciphertext", bus_if.aes_ciphertext,
                 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        check_eq("ecb iv_o", bus_if.iv_o, 128'd0);

        run_op("set_key2", 8'h01, K2, '0, '0, CoreLat + 2, 1'b0);
        check_eq("set_key keeps ciphertext", bus_if.aes_ciphertext,
                 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        run_op("set_iv", 8'h02, K2, K1, '0, 1, 1'b0);
        check_eq("set_iv iv_o", bus_if.iv_o, K1);
        run_op("cbc1", 8'h20, K2, '0, P1, CoreLat + 2, 1'b0);
        check_eq("cbc1 ciphertext", bus_if.aes_ciphertext, C1);
        check_eq("cbc1 iv_o", bus_if.iv_o, C1);
        run_op("cbc2", 8'h20, K2, '0, P2, CoreLat + 2, 1'b0);
        check_eq("cbc2 ciphertext", bus_if.aes_ciphertext, C2);
        check_eq("cbc2 iv_o", bus_if.iv_o, C2);

`ifdef AES_CTR_EN
        run_op("ctr_iv", 8'h02, K2, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, '0, 1, 1'b0);
        run_op("ctr", 8'h40, K2, '0, P1, CoreLat + 2, 1'b0);
        check_eq("ctr ciphertext", bus_if.aes_ciphertext,
                 128'h874d6191b620e3261bef6864990db6ce);
        check_eq("ctr iv_o", bus_if.iv_o, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00);
        run_op("wrap_iv", 8'h02, K2, 128'h0123456789abcdef01234567ffffffff, '0, 1, 1'b0);
        run_op("ctr_wrap", 8'h40, K2, '0, P2, CoreLat + 2, 1'b0);
        exp_iv = 128'h0123456789abcdef0123456700000000;
        exp_ct = P2 ^ K2 ^ 128'h0123456789abcdef01234567ffffffff;
        check_eq("ctr wrap iv_o", bus_if.iv_o, exp_iv);
        check_eq("ctr wrap ciphertext", bus_if.aes_ciphertext, exp_ct);
`else
        exp_iv = C2;
        exp_ct = C2;
        run_op("ctr_disabled", 8'h40, K2, '0, P1, 1, 1'b1);
        check_eq("ctr_disabled iv_o", bus_if.iv_o, exp_iv);
        check_eq("ctr_disabled ciphertext", bus_if.aes_ciphertext, exp_ct);
`endif

        run_op("bad_op", 8'h77, K1, 128'h55, 128'h66, 1, 1'b1);
        check_eq("bad_op iv_o", bus_if.iv_o, exp_iv);
        check_eq("bad_op ciphertext", bus_if.aes_ciphertext, exp_ct);

        // core_en_o while idle must not touch the result.
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        check_eq("spurious done ciphertext", bus_if.aes_ciphertext, exp_ct);
        @(negedge clk);
        check_eq("spurious done en_o", 128'(bus_if.en_o), 128'd0);

        // SET_IV strobed in the middle of an ECB operation is dropped.
        drive(8'h10, K2, '0, P1);
        @(negedge clk);
        bus_if.en = 1'b0;
        @(negedge clk);
        drive(8'h02, K2, 128'h1234, '0);
        @(negedge clk);
        bus_if.en = 1'b0;
        lat = 3;
        while (!bus_if.en_o && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        exp_ct = P1 ^ K2;
        check_eq("busy_ignore latency", 128'(lat), 128'(CoreLat + 2));
        check_eq("busy_ignore ciphertext", bus_if.aes_ciphertext, exp_ct);
        check_eq("busy_ignore iv_o", bus_if.iv_o, exp_iv);
        @(negedge clk);
        check_eq("busy_ignore no second en_o", 128'(bus_if.en_o), 128'd0);

        // Back-to-back: new SET_IV accepted in the DONE cycle.
        drive(8'h02, K2, 128'haaaa, '0);
        @(negedge clk);
        check_eq("b2b first en_o", 128'(bus_if.en_o), 128'd1);
        drive(8'h02, K2, 128'hbbbb, '0);
        @(negedge clk);
        bus_if.en = 1'b0;
        exp_iv = 128'hbbbb;
        check_eq("b2b second en_o", 128'(bus_if.en_o), 128'd1);
        check_eq("b2b iv_o", bus_if.iv_o, exp_iv);
        @(negedge clk);
        check_eq("b2b en_o drops", 128'(bus_if.en_o), 128'd0);

        // Reset while waiting on the core.
        drive(8'h10, K2, '0, P2);
        @(negedge clk);
        bus_if.en = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("pre-reset busy", 128'(bus_if.busy), 128'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid reset en_o", 128'(bus_if.en_o), 128'd0);
        check_eq("mid reset busy", 128'(bus_if.busy), 128'd0);
        check_eq("mid reset core_en", 128'(bus_if.core_en), 128'd0);
        check_eq("mid reset iv_o", bus_if.iv_o, 128'd0);
        check_eq("mid reset ciphertext", bus_if.aes_ciphertext, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus_if.en_o) pulses++;
        end
        check_eq("no en_o after reset", 128'(pulses), 128'd0);

        run_op("post_reset_key", 8'h01, K1, '0, '0, CoreLat + 2, 1'b0);
        run_op("post_reset_ecb", 8'h10, K1, '0, 128'h00112233445566778899aabbccddeeff,
               CoreLat + 2, 1'b0);
        check_eq("post_reset ciphertext", bus_if.aes_ciphertext,
                 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
